// File: rtl/rf_pkg.sv
// Shared types and defaults for the integer register file and its dump sequencer.
package rf_pkg;

    localparam int          DEFAULT_XLEN      = 32;
    localparam int          DEFAULT_REG_COUNT = 32;
    localparam logic [31:0] DEFAULT_SP_INIT   = 32'h010f_423c;
    localparam int          X0_INDEX          = 0;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/rf_dump_sequencer.sv
// Purpose: streams every register out as one valid/ready beat per index, then pulses dump_done.
// Latency: first beat one cycle after dump_req; dump_done one cycle after the last accepted beat.
// Backpressure: dump_ready=0 holds the current index; the presented data follows the live register.
module rf_dump_sequencer
    import rf_pkg::*;
#(
    parameter int XLEN      = DEFAULT_XLEN,
    parameter int REG_COUNT = DEFAULT_REG_COUNT,
    parameter int ADDR_W    = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dump_req,
    input  logic              dump_ready,
    input  logic [XLEN-1:0]   rd_data,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_index,
    output logic [XLEN-1:0]   dump_data,
    output logic              dump_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

    dump_state_t       state;
    dump_state_t       state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DUMP_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        dump_busy  = 1'b0;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        case (state)
            DUMP_IDLE: begin
                idx_nxt = '0;
                if (dump_req) begin
                    state_nxt = DUMP_SEND;
                end
            end
            DUMP_SEND: begin
                dump_busy  = 1'b1;
                dump_valid = 1'b1;
                if (dump_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DUMP_DONE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            DUMP_DONE: begin
                dump_busy = 1'b1;
                dump_done = 1'b1;
                state_nxt = DUMP_IDLE;
                idx_nxt   = '0;
            end
            default: begin
                state_nxt = DUMP_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign dump_index = idx;
    assign dump_data  = rd_data;

endmodule

// File: rtl/param_register_file_module.sv
// Purpose: integer register file, two combinational reads, one write, x0 hardwired, SP preset.
// Latency: reads combinational (optionally bypassing the same-cycle write); writes commit at the edge.
// Backpressure: none on read/write; the dump stream stalls on dump_ready without blocking writes.
module param_register_file_module
    import rf_pkg::*;
#(
    parameter int          XLEN      = DEFAULT_XLEN,
    parameter int          REG_COUNT = DEFAULT_REG_COUNT,
    parameter int          ADDR_W    = 5,
    parameter int          SP_INDEX  = 2,
    parameter logic [31:0] SP_INIT   = DEFAULT_SP_INIT,
    parameter int          BYPASS    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_rs1,
    input  logic [ADDR_W-1:0] addr_rs2,
    output logic [XLEN-1:0]   data_rs1,
    output logic [XLEN-1:0]   data_rs2,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] addr_rd,
    input  logic [XLEN-1:0]   data_rd,
    input  logic              dump_req,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_index,
    output logic [XLEN-1:0]   dump_data,
    output logic              dump_done
);

    localparam logic [XLEN-1:0] SP_RESET = XLEN'(SP_INIT);

    logic [XLEN-1:0] regs [REG_COUNT];
    logic            wr_hit;
    logic [XLEN-1:0] dump_word;

    // Nonzero and backed by storage; x0 and out-of-range indices are never written and read as zero.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return (addr != ADDR_W'(X0_INDEX)) && (32'(addr) < 32'(REG_COUNT));
    endfunction

    assign wr_hit = write_enable && addr_valid(addr_rd);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
        end else if (wr_hit) begin
            regs[addr_rd] <= data_rd;
        end
    end

    always_comb begin
        data_rs1 = addr_valid(addr_rs1) ? regs[addr_rs1] : '0;
        data_rs2 = addr_valid(addr_rs2) ? regs[addr_rs2] : '0;
        if (BYPASS != 0 && wr_hit && addr_rs1 == addr_rd) begin
            data_rs1 = data_rd;
        end
        if (BYPASS != 0 && wr_hit && addr_rs2 == addr_rd) begin
            data_rs2 = data_rd;
        end
    end

    // The dump always shows committed state, never the bypassed write.
    assign dump_word = regs[dump_index];

    rf_dump_sequencer #(
        .XLEN      (XLEN),
        .REG_COUNT (REG_COUNT),
        .ADDR_W    (ADDR_W)
    ) u_dump_seq (
        .clock      (clock),
        .reset      (reset),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .rd_data    (dump_word),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_index (dump_index),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

endmodule
